// File: rtl/l1d_data_ram_bank_pipe_pkg.sv
// Shared widths, request payload and bank-address helpers for the L1D data-RAM bank pipeline.
package l1d_data_ram_bank_pipe_pkg;

    localparam int unsigned L1D_DAT_BANKS       = 4;
    localparam int unsigned L1D_DAT_LINE_WIDTH  = 128;
    localparam int unsigned L1D_DAT_BE_WIDTH    = L1D_DAT_LINE_WIDTH / 8;
    localparam int unsigned L1D_BANK_ADDR_WIDTH = 6;
    localparam int unsigned L1D_ID_WIDTH        = 4;
    localparam int unsigned L1D_SB_WIDTH        = 16;
    localparam int unsigned L1D_EVICT_DEPTH     = 4;
    localparam int unsigned L1D_BANK_BITS       = $clog2(L1D_DAT_BANKS);
    localparam int unsigned L1D_BANK_IDX_W      = (L1D_BANK_BITS > 0) ? L1D_BANK_BITS : 1;
    localparam int unsigned L1D_ADDR_WIDTH      = L1D_BANK_ADDR_WIDTH + L1D_BANK_BITS;

    typedef struct packed {
        logic [L1D_ADDR_WIDTH-1:0]     addr;
        logic                          rw_type;
        logic                          op_is_downstream;
        logic [L1D_DAT_LINE_WIDTH-1:0] data;
        logic [L1D_DAT_BE_WIDTH-1:0]   be;
        logic [L1D_ID_WIDTH-1:0]       id;
        logic [L1D_SB_WIDTH-1:0]       sb;
    } pack_dat_bank_pld;

    typedef struct packed {
        logic [L1D_ID_WIDTH-1:0]       id;
        logic [L1D_DAT_LINE_WIDTH-1:0] dat;
    } evict_ent_t;

    function automatic logic [L1D_BANK_IDX_W-1:0] bank_of(input logic [L1D_ADDR_WIDTH-1:0] addr);
        return L1D_BANK_IDX_W'(addr & L1D_ADDR_WIDTH'(L1D_DAT_BANKS - 1));
    endfunction

    function automatic logic [L1D_BANK_ADDR_WIDTH-1:0] word_of(input logic [L1D_ADDR_WIDTH-1:0] addr);
        return L1D_BANK_ADDR_WIDTH'(addr >> L1D_BANK_BITS);
    endfunction

endpackage

// File: rtl/l1d_data_ram_bank_pipe_if.sv
// Request, upstream-ack and evict handshake bundle for the L1D data-RAM bank pipeline.
interface l1d_data_ram_bank_pipe_if;
    import l1d_data_ram_bank_pipe_pkg::*;

    logic                          in_vld;
    logic                          in_rdy;
    pack_dat_bank_pld              in_pld;
    logic                          ack_vld;
    logic [L1D_DAT_LINE_WIDTH-1:0] ack_dat;
    logic [L1D_SB_WIDTH-1:0]       ack_sb;
    logic                          evict_vld;
    logic                          evict_rdy;
    logic [L1D_ID_WIDTH-1:0]       evict_id;
    logic [L1D_DAT_LINE_WIDTH-1:0] evict_dat;

    modport master (output in_vld, in_pld, evict_rdy,
                    input  in_rdy, ack_vld, ack_dat, ack_sb, evict_vld, evict_id, evict_dat);
    modport slave  (input  in_vld, in_pld, evict_rdy,
                    output in_rdy, ack_vld, ack_dat, ack_sb, evict_vld, evict_id, evict_dat);
endinterface

// File: rtl/l1d_data_ram_bank_pipe_bank.sv
// One data-RAM bank: single-port SRAM plus the read-modify-write merge stage.
// L1D_DATA_RAM_PARITY_EN adds one even-parity bit per byte and a read-side check.
module l1d_data_ram_bank_pipe_bank
    import l1d_data_ram_bank_pipe_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = L1D_DAT_LINE_WIDTH,
    parameter int unsigned ADDR_WIDTH = L1D_BANK_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    full_wr,
    input  logic                    part_wr,
    input  logic [ADDR_WIDTH-1:0]   word,
    input  logic [LINE_WIDTH-1:0]   data,
    input  logic [LINE_WIDTH/8-1:0] be,
    output logic [LINE_WIDTH-1:0]   rd_dat,
    output logic                    busy
`ifdef L1D_DATA_RAM_PARITY_EN
    ,
    output logic                    par_err
`endif
);
    localparam int unsigned BE_W = LINE_WIDTH / 8;
`ifdef L1D_DATA_RAM_PARITY_EN
    localparam int unsigned SRAM_W = LINE_WIDTH + BE_W;
`else
    localparam int unsigned SRAM_W = LINE_WIDTH;
`endif

    logic [SRAM_W-1:0]     mem [2**ADDR_WIDTH];
    logic [SRAM_W-1:0]     rd_q;
    logic [SRAM_W-1:0]     wr_word;
    logic [ADDR_WIDTH-1:0] m_word;
    logic [LINE_WIDTH-1:0] m_data;
    logic [BE_W-1:0]       m_be;
    logic [LINE_WIDTH-1:0] merged;
    logic [LINE_WIDTH-1:0] wr_data;

    // Merge new bytes over the word read in S0; the busy cycle owns the SRAM port.
    always_comb begin
        merged = '0;
        for (int i = 0; i < int'(BE_W); i++) begin
            merged[i*8 +: 8] = m_be[i] ? m_data[i*8 +: 8] : rd_q[i*8 +: 8];
        end
        wr_data = busy ? merged : data;
    end

`ifdef L1D_DATA_RAM_PARITY_EN
    function automatic logic [BE_W-1:0] par_of(input logic [LINE_WIDTH-1:0] d);
        logic [BE_W-1:0] p;
        for (int i = 0; i < int'(BE_W); i++) p[i] = ^d[i*8 +: 8];
        return p;
    endfunction

    assign wr_word = {par_of(wr_data), wr_data};
    assign par_err = (par_of(rd_q[LINE_WIDTH-1:0]) != rd_q[SRAM_W-1:LINE_WIDTH]);
`else
    assign wr_word = wr_data;
`endif

    assign rd_dat = rd_q[LINE_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[m_word] <= wr_word;
        end else if (en && full_wr) begin
            mem[word] <= wr_word;
        end else if (en) begin
            rd_q <= mem[word];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            m_word <= '0;
            m_data <= '0;
            m_be   <= '0;
        end else begin
            busy <= en && part_wr;
            if (en && part_wr) begin
                m_word <= word;
                m_data <= data;
                m_be   <= be;
            end
        end
    end

endmodule

// File: rtl/l1d_data_ram_bank_pipe.sv
// Banked L1D data-RAM pipeline: request admission, S1/S2 pipeline, ack output and evict FIFO.
// L1D_DATA_RAM_PARITY_EN enables per-byte parity storage and the par_err port.
module l1d_data_ram_bank_pipe
    import l1d_data_ram_bank_pipe_pkg::*;
#(
    // Widths must agree with the payload struct in the package.
    parameter int unsigned NUM_BANKS       = L1D_DAT_BANKS,
    parameter int unsigned LINE_WIDTH      = L1D_DAT_LINE_WIDTH,
    parameter int unsigned BANK_ADDR_WIDTH = L1D_BANK_ADDR_WIDTH,
    parameter int unsigned ID_WIDTH        = L1D_ID_WIDTH,
    parameter int unsigned SB_WIDTH        = L1D_SB_WIDTH,
    parameter int unsigned EVICT_DEPTH     = L1D_EVICT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    l1d_data_ram_bank_pipe_if.slave   bus
`ifdef L1D_DATA_RAM_PARITY_EN
    ,
    output logic                      par_err
`endif
);
    localparam int unsigned BIDX_W = L1D_BANK_IDX_W;
    localparam int unsigned CNT_W  = $clog2(EVICT_DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(EVICT_DEPTH);

    pack_dat_bank_pld           req;
    logic [BIDX_W-1:0]          sel;
    logic [BANK_ADDR_WIDTH-1:0] word;
    logic                       part_wr, ds_rd, no_credit, hs;
    logic [NUM_BANKS-1:0]       busy;
    logic [LINE_WIDTH-1:0]      bank_rd [NUM_BANKS];

    logic                       s1_vld, s1_ack, s1_evict, s1_read;
    logic [BIDX_W-1:0]          s1_bank;
    logic [ID_WIDTH-1:0]        s1_id;
    logic [SB_WIDTH-1:0]        s1_sb;
    logic [LINE_WIDTH-1:0]      s1_rd_dat;

    evict_ent_t                 fifo [EVICT_DEPTH];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           cnt;
    logic                       push, pop;

`ifdef L1D_DATA_RAM_PARITY_EN
    logic [NUM_BANKS-1:0]       bank_err;
    logic                       s1_rd_used;
`endif

    // Admission: busy bank blocks everything to it, evict credits block downstream reads only.
    always_comb begin
        req        = bus.in_pld;
        sel        = bank_of(req.addr);
        word       = word_of(req.addr);
        part_wr    = !req.rw_type && !req.op_is_downstream && (req.be != '1);
        ds_rd      = req.op_is_downstream && req.rw_type;
        no_credit  = ({1'b0, cnt} + (CNT_W+1)'(s1_vld && s1_evict)) >= (CNT_W+1)'(EVICT_DEPTH);
        bus.in_rdy = !busy[sel] && !(ds_rd && no_credit);
        hs         = bus.in_vld && bus.in_rdy;
    end

    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        l1d_data_ram_bank_pipe_bank #(
            .LINE_WIDTH (LINE_WIDTH),
            .ADDR_WIDTH (BANK_ADDR_WIDTH)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .en      (hs && (sel == BIDX_W'(b))),
            .full_wr (!req.rw_type && !part_wr),
            .part_wr (part_wr),
            .word    (word),
            .data    (req.data),
            .be      (req.be),
            .rd_dat  (bank_rd[b]),
            .busy    (busy[b])
`ifdef L1D_DATA_RAM_PARITY_EN
            ,
            .par_err (bank_err[b])
`endif
        );
    end

    assign s1_rd_dat = bank_rd[s1_bank];

    // S1 tracking register and S2 result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld      <= 1'b0;
            s1_ack      <= 1'b0;
            s1_evict    <= 1'b0;
            s1_read     <= 1'b0;
            s1_bank     <= '0;
            s1_id       <= '0;
            s1_sb       <= '0;
            bus.ack_vld <= 1'b0;
            bus.ack_dat <= '0;
            bus.ack_sb  <= '0;
`ifdef L1D_DATA_RAM_PARITY_EN
            s1_rd_used  <= 1'b0;
            par_err     <= 1'b0;
`endif
        end else begin
            s1_vld <= hs;
            if (hs) begin
                s1_ack   <= !req.op_is_downstream;
                s1_evict <= ds_rd;
                s1_read  <= req.rw_type;
                s1_bank  <= sel;
                s1_id    <= req.id;
                s1_sb    <= req.sb;
`ifdef L1D_DATA_RAM_PARITY_EN
                s1_rd_used <= req.rw_type || part_wr;
`endif
            end
            bus.ack_vld <= s1_vld && s1_ack;
            if (s1_vld && s1_ack) begin
                bus.ack_dat <= s1_read ? s1_rd_dat : '0;
                bus.ack_sb  <= s1_sb;
            end
`ifdef L1D_DATA_RAM_PARITY_EN
            par_err <= s1_vld && s1_rd_used && bank_err[s1_bank];
`endif
        end
    end

    assign push = s1_vld && s1_evict;
    assign pop  = bus.evict_vld && bus.evict_rdy;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(EVICT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= {s1_id, s1_rd_dat};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.evict_vld = (cnt != '0);
    assign bus.evict_id  = bus.evict_vld ? fifo[rd_ptr].id  : '0;
    assign bus.evict_dat = bus.evict_vld ? fifo[rd_ptr].dat : '0;

endmodule

// File: tb/tb_l1d_data_ram_bank_pipe.sv
// Directed bench for l1d_data_ram_bank_pipe with hand-computed expected values.
module tb_l1d_data_ram_bank_pipe;
    import l1d_data_ram_bank_pipe_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   k, n_ev;
    logic acc_now, ack_seen;

    logic [7:0]   ds_addr [6];
    logic [127:0] ds_dat  [6];

    localparam logic [127:0] LINE_A5 = {16{8'hA5}};
    localparam logic [127:0] LINE_01 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] LINE_P1 = 128'h0f0e0d0c0b0a090807060504030201ff;
    localparam logic [127:0] LINE_P2 = 128'h0f0e0d0c0b0a0908070605040302eeff;
    localparam logic [127:0] LINE_D1 = {4{32'hDEADBEEF}};

    l1d_data_ram_bank_pipe_if bus ();

`ifdef L1D_DATA_RAM_PARITY_EN
    logic par_err;
    l1d_data_ram_bank_pipe dut (.clk(clk), .rst(rst), .bus(bus), .par_err(par_err));
`else
    l1d_data_ram_bank_pipe dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pack_dat_bank_pld mk(input logic [7:0] addr, input logic rw, input logic ds,
                                            input logic [127:0] data, input logic [15:0] be,
                                            input logic [3:0] id, input logic [15:0] sb);
        pack_dat_bank_pld p;
        p.addr = addr;
        p.rw_type = rw;
        p.op_is_downstream = ds;
        p.data = data;
        p.be = be;
        p.id = id;
        p.sb = sb;
        return p;
    endfunction

    // Present one request for a single cycle; caller is then in cycle T+1.
    task automatic issue(input pack_dat_bank_pld p);
        bus.in_vld = 1'b1;
        bus.in_pld = p;
        #1;
        chk("issue_rdy", 128'(bus.in_rdy), 128'd1);
        tick();
        bus.in_vld = 1'b0;
    endtask

    initial begin
        ds_addr[0] = 8'h10; ds_addr[1] = 8'h20; ds_addr[2] = 8'h11;
        ds_addr[3] = 8'h10; ds_addr[4] = 8'h20; ds_addr[5] = 8'h11;
        ds_dat[0] = LINE_A5; ds_dat[1] = LINE_P2; ds_dat[2] = LINE_D1;
        ds_dat[3] = LINE_A5; ds_dat[4] = LINE_P2; ds_dat[5] = LINE_D1;

        rst = 1'b1;
        bus.in_vld = 1'b0;
        bus.in_pld = '0;
        bus.evict_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_rdy", 128'(bus.in_rdy), 128'd1);
        chk("rst_ack_vld", 128'(bus.ack_vld), 128'd0);
        chk("rst_ack_dat", bus.ack_dat, 128'd0);
        chk("rst_ack_sb", 128'(bus.ack_sb), 128'd0);
        chk("rst_evict_vld", 128'(bus.evict_vld), 128'd0);
        chk("rst_evict_id", 128'(bus.evict_id), 128'd0);
        chk("rst_evict_dat", bus.evict_dat, 128'd0);
        rst = 1'b0;
        tick();

        // Full write then read of 0x10.
        issue(mk(8'h10, 1'b0, 1'b0, LINE_A5, 16'hFFFF, 4'd0, 16'h1111));
        chk("fw_t1_ack_vld", 128'(bus.ack_vld), 128'd0);
        tick();
        chk("fw_ack_vld", 128'(bus.ack_vld), 128'd1);
        chk("fw_ack_sb", 128'(bus.ack_sb), 128'h1111);
        chk("fw_ack_dat", bus.ack_dat, 128'd0);
        issue(mk(8'h10, 1'b1, 1'b0, '0, '0, 4'd0, 16'h2222));
        tick();
        chk("rd_ack_vld", 128'(bus.ack_vld), 128'd1);
        chk("rd_ack_dat", bus.ack_dat, LINE_A5);
        chk("rd_ack_sb", 128'(bus.ack_sb), 128'h2222);

        // Partial write byte0 of 0x20, then a same-word read that must stall one cycle.
        issue(mk(8'h20, 1'b0, 1'b0, LINE_01, 16'hFFFF, 4'd0, 16'h0020));
        tick();
        chk("fw20_ack_vld", 128'(bus.ack_vld), 128'd1);
        bus.in_vld = 1'b1;
        bus.in_pld = mk(8'h20, 1'b0, 1'b0, 128'hFF, 16'h0001, 4'd0, 16'h3333);
        tick();
        bus.in_pld = mk(8'h20, 1'b1, 1'b0, '0, '0, 4'd0, 16'h4444);
        #1;
        chk("pw_busy_rdy", 128'(bus.in_rdy), 128'd0);
        tick();
        chk("pw_ack_vld", 128'(bus.ack_vld), 128'd1);
        chk("pw_ack_sb", 128'(bus.ack_sb), 128'h3333);
        chk("pw_ack_dat", bus.ack_dat, 128'd0);
        chk("pw_t2_rdy", 128'(bus.in_rdy), 128'd1);
        tick();
        bus.in_vld = 1'b0;
        chk("stall_t3_ack_vld", 128'(bus.ack_vld), 128'd0);
        tick();
        chk("merge_rd_ack_vld", 128'(bus.ack_vld), 128'd1);
        chk("merge_rd_ack_dat", bus.ack_dat, LINE_P1);
        chk("merge_rd_ack_sb", 128'(bus.ack_sb), 128'h4444);

        // Partial write to bank 0 with a bank-1 read right behind it.
        issue(mk(8'h11, 1'b0, 1'b0, LINE_D1, 16'hFFFF, 4'd0, 16'h0011));
        tick();
        bus.in_vld = 1'b1;
        bus.in_pld = mk(8'h20, 1'b0, 1'b0, 128'hEE00, 16'h0002, 4'd0, 16'h5555);
        tick();
        bus.in_pld = mk(8'h11, 1'b1, 1'b0, '0, '0, 4'd0, 16'h6666);
        #1;
        chk("xbank_rdy", 128'(bus.in_rdy), 128'd1);
        tick();
        bus.in_vld = 1'b0;
        chk("xbank_pw_ack_vld", 128'(bus.ack_vld), 128'd1);
        chk("xbank_pw_ack_sb", 128'(bus.ack_sb), 128'h5555);
        tick();
        chk("xbank_rd_ack_vld", 128'(bus.ack_vld), 128'd1);
        chk("xbank_rd_ack_sb", 128'(bus.ack_sb), 128'h6666);
        chk("xbank_rd_ack_dat", bus.ack_dat, LINE_D1);
        issue(mk(8'h20, 1'b1, 1'b0, '0, '0, 4'd0, 16'h7070));
        tick();
        chk("merge2_ack_dat", bus.ack_dat, LINE_P2);
        tick();

        // Six downstream reads with evict_rdy low: four fit the credits.
        bus.evict_rdy = 1'b0;
        k = 0;
        ack_seen = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            bus.in_vld = 1'b1;
            bus.in_pld = mk(ds_addr[k], 1'b1, 1'b1, '0, '0, 4'(k + 1), 16'h0);
            #1;
            acc_now = bus.in_vld && bus.in_rdy;
            if (bus.ack_vld) ack_seen = 1'b1;
            tick();
            if (acc_now) k++;
        end
        bus.in_vld = 1'b0;
        #1;
        chk("credit_accepted", 128'(k), 128'd4);
        chk("credit_blocked_rdy", 128'(bus.in_rdy), 128'd0);
        chk("credit_evict_vld", 128'(bus.evict_vld), 128'd1);
        chk("credit_head_id", 128'(bus.evict_id), 128'd1);
        chk("ds_no_ack", 128'(ack_seen), 128'd0);
        bus.in_pld = mk(8'h10, 1'b1, 1'b0, '0, '0, 4'd0, 16'h0);
        #1;
        chk("upstream_rdy_when_full", 128'(bus.in_rdy), 128'd1);

        bus.evict_rdy = 1'b1;
        n_ev = 0;
        for (int cyc = 0; cyc < 40 && n_ev < 6; cyc++) begin
            if (k < 6) begin
                bus.in_vld = 1'b1;
                bus.in_pld = mk(ds_addr[k], 1'b1, 1'b1, '0, '0, 4'(k + 1), 16'h0);
            end else begin
                bus.in_vld = 1'b0;
            end
            #1;
            acc_now = bus.in_vld && bus.in_rdy;
            if (bus.evict_vld) begin
                chk($sformatf("evict_id_%0d", n_ev), 128'(bus.evict_id), 128'(n_ev + 1));
                chk($sformatf("evict_dat_%0d", n_ev), bus.evict_dat, ds_dat[n_ev]);
                n_ev++;
            end
            tick();
            if (acc_now) k++;
        end
        bus.in_vld = 1'b0;
        chk("evict_total", 128'(n_ev), 128'd6);

        // Reset during a merge with two evicts queued.
        bus.evict_rdy = 1'b0;
        bus.in_vld = 1'b1;
        bus.in_pld = mk(8'h10, 1'b1, 1'b1, '0, '0, 4'd7, 16'h0);
        tick();
        bus.in_pld = mk(8'h10, 1'b1, 1'b1, '0, '0, 4'd8, 16'h0);
        tick();
        bus.in_vld = 1'b0;
        tick();
        bus.in_vld = 1'b1;
        bus.in_pld = mk(8'h20, 1'b0, 1'b0, 128'h330000, 16'h0004, 4'd0, 16'h7777);
        tick();
        bus.in_vld = 1'b0;
        #1;
        chk("pre_rst_busy_rdy", 128'(bus.in_rdy), 128'd0);
        chk("pre_rst_evict_vld", 128'(bus.evict_vld), 128'd1);
        chk("pre_rst_evict_id", 128'(bus.evict_id), 128'd7);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack_vld", 128'(bus.ack_vld), 128'd0);
        chk("mid_rst_ack_dat", bus.ack_dat, 128'd0);
        chk("mid_rst_ack_sb", 128'(bus.ack_sb), 128'd0);
        chk("mid_rst_evict_vld", 128'(bus.evict_vld), 128'd0);
        chk("mid_rst_evict_id", 128'(bus.evict_id), 128'd0);
        chk("mid_rst_evict_dat", bus.evict_dat, 128'd0);
        chk("mid_rst_in_rdy", 128'(bus.in_rdy), 128'd1);
        tick();
        rst = 1'b0;
        bus.evict_rdy = 1'b1;
        tick();

`ifdef L1D_DATA_RAM_PARITY_EN
        issue(mk(8'h30, 1'b0, 1'b0, {16{8'h3C}}, 16'hFFFF, 4'd0, 16'h0030));
        tick();
        issue(mk(8'h30, 1'b1, 1'b0, '0, '0, 4'd0, 16'h0031));
        tick();
        chk("par_clean_ack", 128'(bus.ack_vld), 128'd1);
        chk("par_clean_err", 128'(par_err), 128'd0);
        dut.g_bank[0].u_bank.mem[12] = dut.g_bank[0].u_bank.mem[12] ^ 144'd1;
        issue(mk(8'h30, 1'b1, 1'b0, '0, '0, 4'd0, 16'h0032));
        tick();
        chk("par_flip_ack", 128'(bus.ack_vld), 128'd1);
        chk("par_flip_err", 128'(par_err), 128'd1);
        chk("par_flip_dat", bus.ack_dat, {16{8'h3C}} ^ 128'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
